// File: rtl/sensor_scan_ctrl.sv
// rtl/sensor_scan_ctrl.sv - round-robin excitation/debounce scan controller for a shared-sense-line sensor array
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   en         scan enable (level)
//   sense_n    shared sense line, asynchronous, 0 = wet
//   drive      per-sensor excitation enables, at most one bit high
//   wet        debounced wet/dry mask, 1 = wet
//   led        copy of wet for the indicator LEDs
//   any_wet    OR of wet
//   scan_done  one-cycle pulse in the NEXT cycle of the last sensor
module sensor_scan_ctrl #(
    parameter int N_SENS     = 5,
    parameter int SETTLE_CYC = 1000,
    parameter int NSAMP      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sense_n,
    output logic [N_SENS-1:0] drive,
    output logic [N_SENS-1:0] wet,
    output logic [N_SENS-1:0] led,
    output logic              any_wet,
    output logic              scan_done
);

    localparam int IDX_W   = $clog2(N_SENS);
    localparam int CNT_MAX = (SETTLE_CYC > NSAMP) ? SETTLE_CYC : NSAMP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int LO_W    = $clog2(NSAMP + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] SAMP_LAST   = CNT_W'(NSAMP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_SENS - 1);
    localparam logic [LO_W-1:0]  LO_FULL     = LO_W'(NSAMP);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        NEXT   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LO_W-1:0]     lo_cnt_q, lo_cnt_d;
    logic [N_SENS-1:0]   wet_q, wet_d;
    logic                s_meta_q, s_meta_d;
    logic                s_sync_q, s_sync_d;
    logic [LO_W-1:0]     lo_total;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            lo_cnt_q <= '0;
            wet_q    <= '0;
            s_meta_q <= 1'b1;
            s_sync_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            lo_cnt_q <= lo_cnt_d;
            wet_q    <= wet_d;
            s_meta_q <= s_meta_d;
            s_sync_q <= s_sync_d;
        end
    end

    always_comb begin
        s_meta_d = sense_n;
        s_sync_d = s_meta_q;
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        lo_cnt_d = lo_cnt_q;
        wet_d    = wet_q;
        // Window total including the sample being taken this cycle.
        lo_total = lo_cnt_q + LO_W'(!s_sync_q);

        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (en) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d  = SAMPLE;
                    cnt_d    = '0;
                    lo_cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                lo_cnt_d = lo_total;
                if (cnt_q == SAMP_LAST) begin
                    state_d = NEXT;
                    // Only a unanimous window changes the state; mixed windows hold.
                    if (lo_total == LO_FULL) begin
                        wet_d[idx_q] = 1'b1;
                    end else if (lo_total == '0) begin
                        wet_d[idx_q] = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            NEXT: begin
                // Explicit wrap keeps non-power-of-two arrays in range.
                if (idx_q == IDX_LAST) begin
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
                if (en) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Decoded from registered state, so async reset clears drive without a clock.
    assign drive     = ((state_q == SETTLE) || (state_q == SAMPLE))
                       ? (N_SENS'(1) << idx_q) : '0;
    assign scan_done = (state_q == NEXT) && (idx_q == IDX_LAST);
    assign wet       = wet_q;
    assign led       = wet_q;
    assign any_wet   = |wet_q;

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// tb/tb_sensor_scan_ctrl.sv - self-checking bench for sensor_scan_ctrl
module tb_sensor_scan_ctrl;

    localparam int N      = 5;
    localparam int SETTLE = 4;
    localparam int NSAMP  = 3;
    localparam int SLOT   = SETTLE + NSAMP + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic         sense_n;
    logic [N-1:0] drive, wet, led;
    logic         any_wet, scan_done;

    logic [N-1:0] pat = '0;
    logic         ovr = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: slot position arithmetic and recorded sense history.
    bit           m_active = 1'b0;
    int           m_sensor = 0;
    int           m_pos    = 0;
    logic [N-1:0] m_wet    = '0;
    logic         hist [0:SLOT-1];

    always #5 clk = ~clk;

    assign sense_n = ovr ? 1'b0 : ~(|(drive & pat));

    sensor_scan_ctrl #(
        .N_SENS    (N),
        .SETTLE_CYC(SETTLE),
        .NSAMP     (NSAMP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sense_n  (sense_n),
        .drive    (drive),
        .wet      (wet),
        .led      (led),
        .any_wet  (any_wet),
        .scan_done(scan_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] exp_drive();
        logic [N-1:0] one;
        one = 1;
        if (m_active && m_pos < SLOT - 1) return one << m_sensor;
        return '0;
    endfunction

    // One clock: capture inputs before the edge, advance the model, check at negedge.
    task automatic tick();
        logic s, e, r;
        int   lo;
        #1;
        s = sense_n;
        e = en;
        r = rst;
        @(posedge clk);
        if (r) begin
            m_active = 1'b0;
            m_wet    = '0;
        end else if (!m_active) begin
            if (e) begin
                m_active = 1'b1;
                m_sensor = 0;
                m_pos    = 0;
            end
        end else begin
            hist[m_pos] = s;
            if (m_pos == SETTLE + NSAMP - 1) begin
                // Two-flop latency: samples reflect cycles SETTLE-2 .. SETTLE+NSAMP-3.
                lo = 0;
                for (int k = SETTLE - 2; k <= SETTLE + NSAMP - 3; k++)
                    if (hist[k] == 1'b0) lo++;
                if (lo == NSAMP) m_wet[m_sensor] = 1'b1;
                else if (lo == 0) m_wet[m_sensor] = 1'b0;
                m_pos++;
            end else if (m_pos == SLOT - 1) begin
                if (e) begin
                    m_pos    = 0;
                    m_sensor = (m_sensor + 1) % N;
                end else begin
                    m_active = 1'b0;
                end
            end else begin
                m_pos++;
            end
        end
        @(negedge clk);
        chk("drive", drive, exp_drive());
        chk("wet", wet, m_wet);
        chk("led", led, m_wet);
        chk("any_wet", any_wet, |m_wet);
        chk("scan_done", scan_done,
            m_active && m_pos == SLOT - 1 && m_sensor == N - 1);
    endtask

    task automatic wait_pos(input int s, input int p);
        int i;
        for (i = 0; i < 200 && !(m_active && m_sensor == s && m_pos == p); i++) tick();
        chk("wait_pos", (m_active && m_sensor == s && m_pos == p), 1);
    endtask

    initial begin
        int pulses;
        int i;

        // 1: reset, idle with en low
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        chk("idle_drive", drive, 0);
        chk("idle_wet", wet, 0);

        // 2: all dry, stepping and scan_done cadence
        pat = '0;
        en  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 2 * N * SLOT; k++) begin
            tick();
            if (scan_done) pulses++;
        end
        chk("scan_done_count", pulses, 2);
        chk("dry_wet", wet, 0);

        // 3: single wet sensor, then dry again
        wait_pos(0, 0);
        pat = 5'b00100;
        for (int k = 0; k < N * SLOT; k++) tick();
        chk("pass_wet", wet, 5'b00100);
        chk("pass_led", led, 5'b00100);
        chk("pass_any", any_wet, 1);
        pat = '0;
        for (int k = 0; k < N * SLOT; k++) tick();
        chk("pass_dry", wet, 0);
        chk("pass_dry_any", any_wet, 0);

        // 4: debounce on sensor 1
        wait_pos(1, SETTLE - 2);
        ovr = 1'b1;
        tick();
        ovr = 1'b0;
        wait_pos(1, SLOT - 1);
        chk("debounce_hold", wet[1], 0);
        wait_pos(1, SETTLE - 2);
        ovr = 1'b1;
        for (int k = 0; k < NSAMP; k++) tick();
        ovr = 1'b0;
        wait_pos(1, SLOT - 1);
        chk("debounce_set", wet[1], 1);

        // 5: drop en in sensor 2 SETTLE
        pat = 5'b00100;
        wait_pos(2, 1);
        en = 1'b0;
        for (i = 0; i < 20 && m_active; i++) tick();
        chk("stop_reached", m_active, 0);
        chk("stop_wet2", wet[2], 1);
        chk("stop_drive", drive, 0);
        for (int k = 0; k < 5; k++) tick();
        chk("stop_retain", wet, 5'b00110);
        en = 1'b1;
        tick();
        chk("restart_drive", drive, 5'b00001);

        // random stretch: changing patterns, sense glitches, brief en drops
        for (int k = 0; k < 320; k++) begin
            if (k % 40 == 0) pat = N'($urandom);
            ovr = ($urandom_range(0, 7) == 0);
            en  = ($urandom_range(0, 11) != 0);
            tick();
        end
        ovr = 1'b0;
        en  = 1'b1;

        // 6: async reset during sensor 3 SAMPLE with wet = 11001
        pat = 5'b11001;
        wait_pos(0, 1);
        wait_pos(4, SLOT - 1);
        wait_pos(3, SETTLE + 1);
        chk("pre_rst_wet", wet, 5'b11001);
        #2;
        rst = 1'b1;
        #1;
        chk("async_drive", drive, 0);
        chk("async_wet", wet, 0);
        chk("async_any", any_wet, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("resume_drive", drive, 5'b00001);
        for (int k = 0; k < 10; k++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
